// File: rtl/pux_opnd_stream.sv
// pux_opnd_stream: fetches one A/B/M operand set for pux_si
// interleaved reads, credit-gated into three 2-deep AXIS FIFOs
module pux_opnd_stream #(
  parameter int DATAW = 16,
  parameter int ADDRW = 4,
  parameter int WORDS = 8
) (
  input  logic             axis_clk,
  input  logic             axis_rstn,
  input  logic             stream_reqest,
  output logic             mem_rd_en,
  output logic [ADDRW+1:0] mem_rd_addr,
  input  logic [DATAW-1:0] mem_rd_data,
  output logic [DATAW-1:0] axis_abuff_data,
  output logic             axis_abuff_valid,
  input  logic             axis_abuff_ready,
  output logic [DATAW-1:0] axis_bbuff_data,
  output logic             axis_bbuff_valid,
  input  logic             axis_bbuff_ready,
  output logic [DATAW-1:0] axis_mbuff_data,
  output logic             axis_mbuff_valid,
  input  logic             axis_mbuff_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  localparam logic [ADDRW-1:0] LAST_IDX =
    ADDRW'(WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sel;
  logic [ADDRW-1:0] r_idx;
  logic             r_rd_vld;
  logic [1:0]       r_rd_sel;

  logic [DATAW-1:0] r_fifo [3][2];
  logic             r_rp [3];
  logic             r_wp [3];
  logic [1:0]       r_occ [3];

  logic [2:0] w_rdy;
  logic [2:0] w_push;
  logic [2:0] w_pop;
  logic [1:0] w_occ_cur;
  logic       w_infl;
  logic       w_credit;
  logic       w_last;
  logic       w_empty;
  logic       w_rd_en;
  logic       w_done;

  assign w_rdy = {axis_mbuff_ready,
                  axis_bbuff_ready,
                  axis_abuff_ready};

  // occupancy of the channel currently selected for issue
  always_comb begin
    w_occ_cur = 2'd2;
    unique case (r_sel)
      2'd0: w_occ_cur = r_occ[0];
      2'd1: w_occ_cur = r_occ[1];
      2'd2: w_occ_cur = r_occ[2];
      default: w_occ_cur = 2'd2;
    endcase
  end

  assign w_infl   = r_rd_vld && (r_rd_sel == r_sel);
  assign w_credit = ({1'b0, w_occ_cur}
                   + {2'b00, w_infl}) < 3'd2;
  assign w_last   = (r_sel == 2'd2)
                 && (r_idx == LAST_IDX);
  assign w_empty  = (r_occ[0] == 2'd0)
                 && (r_occ[1] == 2'd0)
                 && (r_occ[2] == 2'd0);

  // next state, read strobe and completion pulse
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (stream_reqest) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_credit) begin
          w_rd_en = 1'b1;
          if (w_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty && !r_rd_vld) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // bank/index walk: A,B,M per index, then next index
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_sel <= 2'd0;
      r_idx <= '0;
    end else if (r_state == S_IDLE) begin
      if (stream_reqest) begin
        r_sel <= 2'd0;
        r_idx <= '0;
      end
    end else if (w_rd_en) begin
      if (r_sel == 2'd2) begin
        r_sel <= 2'd0;
        r_idx <= r_idx + ADDRW'(1);
      end else begin
        r_sel <= r_sel + 2'd1;
      end
    end
  end

  // remember which channel owns the returning word
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_rd_vld <= 1'b0;
      r_rd_sel <= 2'd0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_rd_sel <= r_sel;
    end
  end

  // per-channel push/pop strobes
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int c = 0; c < 3; c++) begin
      w_push[c] = r_rd_vld && (r_rd_sel == 2'(c));
      w_pop[c]  = (r_occ[c] != 2'd0) && w_rdy[c];
    end
  end

  // 2-entry output FIFOs
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      for (int c = 0; c < 3; c++) begin
        r_fifo[c][0] <= '0;
        r_fifo[c][1] <= '0;
        r_rp[c]      <= 1'b0;
        r_wp[c]      <= 1'b0;
        r_occ[c]     <= 2'd0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (w_push[c]) begin
          r_fifo[c][r_wp[c]] <= mem_rd_data;
          r_wp[c] <= ~r_wp[c];
        end
        if (w_pop[c]) r_rp[c] <= ~r_rp[c];
        unique case ({w_push[c], w_pop[c]})
          2'b10:   r_occ[c] <= r_occ[c] + 2'd1;
          2'b01:   r_occ[c] <= r_occ[c] - 2'd1;
          default: r_occ[c] <= r_occ[c];
        endcase
      end
    end
  end

  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = {r_sel, r_idx};

  assign axis_abuff_data  = r_fifo[0][r_rp[0]];
  assign axis_bbuff_data  = r_fifo[1][r_rp[1]];
  assign axis_mbuff_data  = r_fifo[2][r_rp[2]];
  assign axis_abuff_valid = (r_occ[0] != 2'd0);
  assign axis_bbuff_valid = (r_occ[1] != 2'd0);
  assign axis_mbuff_valid = (r_occ[2] != 2'd0);

  assign busy = (r_state != S_IDLE);
  assign done = w_done;

endmodule

// File: tb/tb_pux_opnd_stream.sv
// tb_pux_opnd_stream: three streamers (WORDS 4/8/1)
// checked against per-channel expected word sequences
module tb_pux_opnd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rstn, req, rd_en, busy, done;
  logic [2:0]       av, bv, mv;
  logic [2:0][5:0]  addr;
  logic [2:0][15:0] rdata, ad, bd, md;
  logic [2:0][2:0]  rdy;

  int checks = 0;
  int fails  = 0;

  int         k   [3];
  int         iss [3][3];
  int         pop [3][3];
  logic       pv  [3][3];
  logic       pr  [3][3];
  logic [15:0] pd [3][3];

  pux_opnd_stream #(.DATAW(16), .ADDRW(4), .WORDS(4)) u0 (
    .axis_clk(clk), .axis_rstn(rstn[0]),
    .stream_reqest(req[0]),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(addr[0]),
    .mem_rd_data(rdata[0]),
    .axis_abuff_data(ad[0]), .axis_abuff_valid(av[0]),
    .axis_abuff_ready(rdy[0][0]),
    .axis_bbuff_data(bd[0]), .axis_bbuff_valid(bv[0]),
    .axis_bbuff_ready(rdy[0][1]),
    .axis_mbuff_data(md[0]), .axis_mbuff_valid(mv[0]),
    .axis_mbuff_ready(rdy[0][2]),
    .busy(busy[0]), .done(done[0])
  );

  pux_opnd_stream #(.DATAW(16), .ADDRW(4), .WORDS(8)) u1 (
    .axis_clk(clk), .axis_rstn(rstn[1]),
    .stream_reqest(req[1]),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(addr[1]),
    .mem_rd_data(rdata[1]),
    .axis_abuff_data(ad[1]), .axis_abuff_valid(av[1]),
    .axis_abuff_ready(rdy[1][0]),
    .axis_bbuff_data(bd[1]), .axis_bbuff_valid(bv[1]),
    .axis_bbuff_ready(rdy[1][1]),
    .axis_mbuff_data(md[1]), .axis_mbuff_valid(mv[1]),
    .axis_mbuff_ready(rdy[1][2]),
    .busy(busy[1]), .done(done[1])
  );

  pux_opnd_stream #(.DATAW(16), .ADDRW(4), .WORDS(1)) u2 (
    .axis_clk(clk), .axis_rstn(rstn[2]),
    .stream_reqest(req[2]),
    .mem_rd_en(rd_en[2]), .mem_rd_addr(addr[2]),
    .mem_rd_data(rdata[2]),
    .axis_abuff_data(ad[2]), .axis_abuff_valid(av[2]),
    .axis_abuff_ready(rdy[2][0]),
    .axis_bbuff_data(bd[2]), .axis_bbuff_valid(bv[2]),
    .axis_bbuff_ready(rdy[2][1]),
    .axis_mbuff_data(md[2]), .axis_mbuff_valid(mv[2]),
    .axis_mbuff_ready(rdy[2][2]),
    .busy(busy[2]), .done(done[2])
  );

  function automatic logic [15:0] expv(input int b,
                                       input int i);
    return 16'(32'hA000 + b * 32'h1000 + i);
  endfunction

  function automatic int nw(input int g);
    if (g == 0) return 4;
    if (g == 1) return 8;
    return 1;
  endfunction

  function automatic logic vld(input int g, input int c);
    if (c == 0) return av[g];
    if (c == 1) return bv[g];
    return mv[g];
  endfunction

  function automatic logic [15:0] dat(input int g,
                                      input int c);
    if (c == 0) return ad[g];
    if (c == 1) return bd[g];
    return md[g];
  endfunction

  // operand memory: one-cycle read latency
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++)
      if (rd_en[g])
        rdata[g] <= expv(int'(addr[g][5:4]),
                         int'(addr[g][3:0]));
  end

  task automatic chk(input bit ok, input string nm,
                     input int act, input int want);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, want);
    end
  endtask

  // per-cycle comparison against the expected streams
  task automatic mon();
    for (int g = 0; g < 3; g++) begin
      if (!rstn[g]) begin
        k[g] = 0;
        for (int c = 0; c < 3; c++) begin
          iss[g][c] = 0; pop[g][c] = 0;
          pv[g][c] = 1'b0; pr[g][c] = 1'b0;
          pd[g][c] = '0;
        end
      end else begin
        if (rd_en[g]) begin
          int b, i;
          logic [5:0] e;
          b = k[g] % 3;
          i = k[g] / 3;
          e = 6'(b * 16 + i);
          chk(k[g] < 3 * nw(g), "rd_count",
              k[g], 3 * nw(g) - 1);
          chk(addr[g] == e, "rd_addr",
              int'(addr[g]), int'(e));
          iss[g][b]++;
          chk(iss[g][b] - pop[g][b] <= 2, "credit",
              iss[g][b] - pop[g][b], 2);
          k[g]++;
        end
        for (int c = 0; c < 3; c++) begin
          logic v;
          logic [15:0] d;
          v = vld(g, c);
          d = dat(g, c);
          if (pv[g][c] && !pr[g][c])
            chk(v && d == pd[g][c], "axis_hold",
                {15'd0, v, d}, {16'd1, pd[g][c]});
          if (v && rdy[g][c]) begin
            chk(pop[g][c] < nw(g) &&
                d == expv(c, pop[g][c]), "data",
                int'(d), int'(expv(c, pop[g][c])));
            pop[g][c]++;
          end
          pv[g][c] = v;
          pd[g][c] = d;
          pr[g][c] = rdy[g][c];
        end
        if (k[g] > 0)
          chk(busy[g], "busy", int'(busy[g]), 1);
        if (done[g]) begin
          bit ok;
          ok = (k[g] == 3 * nw(g));
          for (int c = 0; c < 3; c++)
            ok = ok && (pop[g][c] == nw(g));
          chk(ok, "done_cond", k[g], 3 * nw(g));
          k[g] = 0;
          for (int c = 0; c < 3; c++) begin
            iss[g][c] = 0; pop[g][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      step();
      @(posedge clk); #1;
    end
  endtask

  // one request; mode picks the ready/request/reset pattern
  task automatic run(input int g, input int mode,
                     input int maxc);
    int nrd = 0, rdrun = 0, firstv = -1;
    int dp = 0, dc = 0, n;
    bit brk = 0, at_neg = 0, rst = 0;
    logic [15:0] fa = '0;
    logic [5:0] a3 [3];
    a3[0] = '1; a3[1] = '1; a3[2] = '1;
    rdy[g] = 3'b111;
    if (mode == 1) rdy[g][1] = 1'b0;
    req[g] = 1'b1;
    step();
    @(posedge clk); #1;
    req[g] = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      step();
      if (rd_en[g]) begin
        nrd++;
        if (!brk) rdrun++;
        if (nrd <= 3) a3[nrd-1] = addr[g];
      end else if (nrd > 0) begin
        brk = 1;
      end
      if (firstv < 0 && av[g]) begin
        firstv = c;
        fa = ad[g];
      end
      if (done[g]) begin
        dp++;
        dc = c;
      end
      if (mode == 1 && c == 18) begin
        chk(nrd == 7, "bp_stall_reads", nrd, 7);
        chk(bv[g] && bd[g] == 16'hB000, "bp_b_head",
            int'(bd[g]), 16'hB000);
      end
      if (mode == 3 && c == 28)
        chk(busy[g] && nrd == 24 && !done[g],
            "busy_drain", nrd, 24);
      if (dp > 0 && c >= dc + 5) begin
        at_neg = 1;
        break;
      end
      @(posedge clk); #1;
      n = c + 1;
      case (mode)
        1: if (n == 20) rdy[g][1] = 1'b1;
        2: rdy[g] = 3'($urandom);
        3: begin
          req[g] = (n == 3 || n == 28);
          rdy[g][2] = !(n >= 24 && n < 34);
        end
        4: if (nrd == 5) begin
          chk(rd_en[g] && busy[g] && av[g],
              "pre_reset", {rd_en[g], busy[g], av[g]},
              3'b111);
          rstn[g] = 1'b0;
          #1;
          chk({rd_en[g], busy[g], av[g], bv[g], mv[g]}
              == 5'b0, "async_reset",
              {rd_en[g], busy[g], av[g], bv[g], mv[g]},
              0);
          rst = 1;
        end
        default: ;
      endcase
      if (rst) break;
    end
    if (at_neg) begin
      @(posedge clk); #1;
    end
    req[g] = 1'b0;
    rdy[g] = 3'b111;
    if (mode == 4) begin
      chk(rst && dp == 0, "abort_no_done", dp, 0);
    end else begin
      chk(dp == 1, "done_pulses", dp, 1);
      chk(nrd == 3 * nw(g), "reads_total",
          nrd, 3 * nw(g));
      chk(!busy[g], "busy_after", int'(busy[g]), 0);
      if (mode == 0 || mode == 3)
        chk(rdrun == 3 * nw(g), "rd_burst",
            rdrun, 3 * nw(g));
      if (mode == 0) begin
        chk(firstv == 2, "first_valid", firstv, 2);
        chk(fa == 16'hA000, "first_a", int'(fa),
            16'hA000);
        chk(a3[0] == 6'h00, "addr0", int'(a3[0]), 0);
        chk(a3[1] == 6'h10, "addr1", int'(a3[1]),
            6'h10);
        chk(a3[2] == 6'h20, "addr2", int'(a3[2]),
            6'h20);
      end
    end
  endtask

  initial begin
    rstn = '0;
    req  = '0;
    rdy  = '1;
    step();
    step();
    for (int g = 0; g < 3; g++)
      chk({rd_en[g], busy[g], done[g],
           av[g], bv[g], mv[g]} == 6'b0, "reset_state",
          {rd_en[g], busy[g], done[g],
           av[g], bv[g], mv[g]}, 0);
    @(posedge clk); #1;
    rstn = '1;
    cyc(2);
    run(0, 0, 60);
    cyc(3);
    run(1, 1, 150);
    cyc(3);
    run(1, 2, 600);
    cyc(3);
    run(1, 3, 150);
    cyc(3);
    run(1, 4, 60);
    cyc(2);
    rstn[1] = 1'b1;
    cyc(2);
    run(1, 0, 80);
    cyc(3);
    run(2, 0, 40);
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/pux_opnd_stream.md
# pux_opnd_stream

Operand streamer that sits directly upstream of `pux_si`. When `pux_si` raises `stream_reqest`, it fetches one operand set from a single-port operand memory: A, B and M words, interleaved word by word. Each word is delivered on the matching AXI-Stream channel (`axis_abuff_*`, `axis_bbuff_*`, `axis_mbuff_*`). Every channel has a 2-entry output FIFO with credit-based read issue, so backpressure on any channel never loses data.

## Interface
- `DATAW`, 16, operand word width; matches `pux_si` DATAW
- `ADDRW`, 4, word-index width per operand bank
- `WORDS`, 8, words per operand; legal range 1..2^ADDRW
- `axis_clk`  in  1  single clock; all logic on its rising edge
- `axis_rstn`  in  1  reset; asynchronous, active-low
- `stream_reqest`  in  1  fetch request from `pux_si`; level-sampled, honoured only in IDLE
- `mem_rd_en`  out  1  operand-memory read strobe
- `mem_rd_addr`  out  ADDRW+2  read address {bank[1:0], index}; bank A=0, B=1, M=2
- `mem_rd_data`  in  DATAW  read data; valid exactly 1 cycle after `mem_rd_en`
- `axis_abuff_data` / `axis_abuff_valid`  out  DATAW / 1  A stream to `pux_si`
- `axis_abuff_ready`  in  1  A stream ready
- `axis_bbuff_data` / `axis_bbuff_valid`  out  DATAW / 1  B stream
- `axis_bbuff_ready`  in  1  B stream ready
- `axis_mbuff_data` / `axis_mbuff_valid`  out  DATAW / 1  M stream
- `axis_mbuff_ready`  in  1  M stream ready
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse when a complete operand set has been delivered

## Operation
- FSM states:
  - IDLE: `stream_reqest`=1 at an edge → FETCH; clear `idx`; set `sel`=A.
  - FETCH: issues reads in strict order A[0],B[0],M[0],A[1],…,M[WORDS-1]. After `sel`=M, `sel` wraps to A and `idx` increments. Issuing M[WORDS-1] → DRAIN.
  - DRAIN: when all three FIFOs are empty and no read is in flight → IDLE; `done`=1 for that one cycle.
- Read issue rule: `mem_rd_en` = (state==FETCH) && (occ[sel] + inflight[sel] < 2). The rule is combinational, and `mem_rd_addr` = {sel, idx} during that cycle. A stalled channel blocks the whole sequence; there is no skipping to another bank.
- Return path: `sel` is registered alongside `mem_rd_en`. The returned `mem_rd_data` is written into that channel's FIFO at the next edge.
- FIFO: 2 entries per channel; `*_valid` = (occ != 0); `*_data` = head entry. A pop occurs when valid && ready. A push and a pop in the same cycle leave occupancy unchanged.
- `stream_reqest` in FETCH or DRAIN is ignored and not queued.
- Word order on each channel is index 0..WORDS-1; there is no reordering.

## Timing
- Reset (async assert, sync release) values: all `*_valid`=0, `mem_rd_en`=0, `busy`=0, `done`=0, state=IDLE, FIFOs empty, in-flight flag cleared. Data outputs are don't-care (they reset to 0).
- Reset asserted mid-operation aborts immediately: any in-flight return is discarded and no `done` is produced.
- Latency: `stream_reqest` is sampled at edge E0. `mem_rd_en` is high in the cycle after E0. `axis_abuff_valid` rises after E2, i.e. 2 cycles after the request edge.
- Throughput: with all readies held high, one read per cycle, so 3·WORDS consecutive `mem_rd_en` cycles.
- `done` fires 1 cycle after the edge at which the last M word is popped, provided A and B are already empty.
- AXIS rule: while valid && !ready, `*_data` and `*_valid` are held stable.
- Credit accounting includes the in-flight read, so a FIFO never overflows, even with ready low from the first cycle.

## Test plan
- Basic transfer: WORDS=4, memory A[i]=0xA000+i, B[i]=0xB000+i, M[i]=0xC000+i, readies high, request pulse.
  - Required: `mem_rd_en` high for 12 consecutive cycles.
  - Required: A stream 0xA000..0xA003, B stream 0xB000..0xB003, M stream 0xC000..0xC003.
  - Required: first `axis_abuff_valid` 2 cycles after the request edge; exactly one `done` pulse; `busy` low afterwards.
- Backpressure: `axis_bbuff_ready`=0 for 20 cycles, then 1.
  - Required: read issue stalls once B holds 2 words (B[0],B[1]); A occupancy never exceeds 2.
  - Required: after release, all 3·WORDS words are delivered in order with none lost or duplicated.
- Random ready toggling on all three channels, WORDS=8.
  - Required: per-channel sequences match memory contents exactly.
  - Required: data stays stable while valid && !ready; one `done` pulse.
- Request while busy: a second `stream_reqest` pulse during FETCH and again during DRAIN.
  - Required: ignored; exactly 24 reads total; a single `done` pulse.
- Reset mid-operation: assert `axis_rstn`=0 after 5 reads.
  - Required: all valids, `busy` and `mem_rd_en` drop immediately (asynchronous).
  - Required: a new request after release restarts at A[0].
- Edge size WORDS=1.
  - Required: 3 reads (addresses 0x00, 0x10, 0x20 with ADDRW=4), one word per channel, `done` once.
